// File: rtl/undo_log_writer.sv
// Undo-log record drain: buffers core records in a small FIFO and issues each one
// as a single-beat 64-bit write into its CQ slot's region of the undo log.
module undo_log_writer #(
   parameter int SLOT_W          = 7,
   parameter int ID_W            = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       undo_log_valid,
   output logic                                       undo_log_ready,
   input  logic [ID_W-1:0]                            undo_log_id,
   input  logic [31:0]                                undo_log_addr,
   input  logic [31:0]                                undo_log_data,
   input  logic [SLOT_W-1:0]                          undo_log_slot,
   input  logic [63:0]                                base_addr,
   output logic                                       m_awvalid,
   input  logic                                       m_awready,
   output logic [63:0]                                m_awaddr,
   output logic                                       m_wvalid,
   input  logic                                       m_wready,
   output logic [63:0]                                m_wdata,
   output logic [7:0]                                 m_wstrb,
   output logic                                       m_wlast,
   input  logic                                       m_bvalid,
   output logic                                       m_bready,
   input  logic [1:0]                                 m_bresp,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
   output logic                                       idle,
   output logic                                       err,
   output logic [31:0]                                n_writes
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int ENT_W = SLOT_W + ID_W + 64;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTSTANDING);

   logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]      r_wptr, r_rptr;
   logic             r_vld, r_aw_done, r_w_done;
   logic [63:0]      r_awaddr, r_wdata;
   logic [OUT_W-1:0] r_out;
   logic             r_err;
   logic [31:0]      r_nwr;

   logic             w_full, w_empty, w_push, w_load, w_retire;
   logic             w_aw_hs, w_w_hs, w_bdec;
   logic [ENT_W-1:0] w_head;
   logic [63:0]      w_awaddr_nxt;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push  = undo_log_valid & ~w_full;
   assign w_head  = r_mem[r_rptr[AW-1:0]];

   assign w_aw_hs  = m_awvalid & m_awready;
   assign w_w_hs   = m_wvalid & m_wready;
   assign w_retire = r_vld & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
   assign w_load   = (~r_vld | w_retire) & ~w_empty & (r_out < MAX_O);
   assign w_bdec   = m_bvalid & (r_out != '0);

   // Record slot {slot,id} is an 8-byte index into the region.
   assign w_awaddr_nxt = (base_addr & ~64'd7) + 64'({w_head[ENT_W-1:64], 3'b000});

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= {undo_log_slot, undo_log_id, undo_log_data, undo_log_addr};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_load) r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld     <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
      end else if (w_load) begin
         r_vld     <= 1'b1;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_awaddr  <= w_awaddr_nxt;
         r_wdata   <= w_head[63:0];
      end else if (w_retire) begin
         r_vld <= 1'b0;
      end else begin
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
      end
   end

   // A B with nothing outstanding is a slave protocol error; the counter just holds at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out <= '0;
         r_err <= 1'b0;
         r_nwr <= '0;
      end else begin
         case ({w_load, w_bdec})
            2'b10:   r_out <= r_out + OUT_W'(1);
            2'b01:   r_out <= r_out - OUT_W'(1);
            default: r_out <= r_out;
         endcase
         if (m_bvalid && (m_bresp != 2'b00)) r_err <= 1'b1;
         if (m_bvalid) r_nwr <= r_nwr + 32'd1;
      end
   end

   assign undo_log_ready = ~w_full;
   assign m_awvalid      = r_vld & ~r_aw_done;
   assign m_wvalid       = r_vld & ~r_w_done;
   assign m_awaddr       = r_awaddr;
   assign m_wdata        = r_wdata;
   assign m_wstrb        = m_wvalid ? 8'hFF : 8'h00;
   assign m_wlast        = m_wvalid;
   assign m_bready       = 1'b1;
   assign outstanding    = r_out;
   assign idle           = w_empty & (r_out == '0);
   assign err            = r_err;
   assign n_writes       = r_nwr;

endmodule

// File: tb/tb_undo_log_writer.sv
// Bench for undo_log_writer: scoreboard of expected AW/W beats, a simple B-returning
// slave, and one task per scenario.
module tb_undo_log_writer;

   localparam int SLOT_W = 7;
   localparam int ID_W   = 3;
   localparam int FD     = 4;
   localparam int MO     = 4;

   logic              clk, rst;
   logic              undo_log_valid, undo_log_ready;
   logic [ID_W-1:0]   undo_log_id;
   logic [31:0]       undo_log_addr, undo_log_data;
   logic [SLOT_W-1:0] undo_log_slot;
   logic [63:0]       base_addr;
   logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
   logic [63:0]       m_awaddr, m_wdata;
   logic [7:0]        m_wstrb;
   logic              m_bvalid, m_bready;
   logic [1:0]        m_bresp;
   logic [2:0]        outstanding;
   logic              idle, err;
   logic [31:0]       n_writes;

   undo_log_writer #(.SLOT_W(SLOT_W), .ID_W(ID_W), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .rst(rst),
      .undo_log_valid(undo_log_valid), .undo_log_ready(undo_log_ready),
      .undo_log_id(undo_log_id), .undo_log_addr(undo_log_addr),
      .undo_log_data(undo_log_data), .undo_log_slot(undo_log_slot),
      .base_addr(base_addr),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .outstanding(outstanding), .idle(idle), .err(err), .n_writes(n_writes)
   );

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int aw_cnt = 0, w_cnt = 0, b_sent = 0;
   logic b_en = 1'b1, bad_next = 1'b0;
   logic [63:0] exp_aw[$], exp_w[$];
   int aw_cycles[$];
   logic [63:0] e_aw, e_w;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Handshakes observed at the negedge complete at the following posedge.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_awvalid && m_awready) begin
            n_chk++;
            if (exp_aw.size() == 0) begin
               n_fail++; $display("FAIL aw_unexpected: got awaddr %h, required no beat", m_awaddr);
            end else begin
               e_aw = exp_aw.pop_front();
               if (m_awaddr !== e_aw) begin
                  n_fail++; $display("FAIL awaddr: got %h required %h", m_awaddr, e_aw);
               end
            end
            aw_cnt++;
            aw_cycles.push_back(cyc);
         end
         if (m_wvalid && m_wready) begin
            n_chk++;
            if (exp_w.size() == 0) begin
               n_fail++; $display("FAIL w_unexpected: got wdata %h, required no beat", m_wdata);
            end else begin
               e_w = exp_w.pop_front();
               if (m_wdata !== e_w || m_wstrb !== 8'hFF || m_wlast !== 1'b1) begin
                  n_fail++; $display("FAIL wbeat: got %h/%h/%b required %h/ff/1", m_wdata, m_wstrb, m_wlast, e_w);
               end
            end
            w_cnt++;
         end
      end
   end

   // Slave B channel: one response per record that has completed both AW and W.
   initial begin
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            m_bvalid = 1'b0;
            b_sent   = 0;
         end else begin
            if (m_bvalid) b_sent++;
            if (b_en && (((aw_cnt < w_cnt) ? aw_cnt : w_cnt) > b_sent)) begin
               m_bvalid = 1'b1;
               m_bresp  = bad_next ? 2'b10 : 2'b00;
               bad_next = 1'b0;
            end else begin
               m_bvalid = 1'b0;
               m_bresp  = 2'b00;
            end
         end
      end
   end

   task automatic push_rec(input logic [SLOT_W-1:0] s, input logic [ID_W-1:0] id,
                           input logic [31:0] a, input logic [31:0] d, output int waits);
      waits = 0;
      undo_log_valid = 1'b1;
      undo_log_slot  = s;
      undo_log_id    = id;
      undo_log_addr  = a;
      undo_log_data  = d;
      forever begin
         @(negedge clk);
         if (undo_log_ready) begin
            exp_aw.push_back({base_addr[63:3], 3'b000} + (64'(s) << (ID_W + 3)) + (64'(id) << 3));
            exp_w.push_back({d, a});
            break;
         end
         waits++;
         if (waits > 300) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout: got ready=0 for 300 cycles, required acceptance");
            break;
         end
      end
      @(posedge clk); #1;
      undo_log_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (!(idle && exp_aw.size() == 0 && exp_w.size() == 0 && !m_bvalid) && t < 300) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (t >= 300) begin
         n_fail++; $display("FAIL %s_drain: got idle=%b pending=%0d after 300 cycles, required drained", name, idle, exp_aw.size());
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({undo_log_ready, m_awvalid, m_wvalid, m_wlast, m_bready, idle, err} !== 7'b1000110 ||
          outstanding !== 3'd0 || n_writes !== 32'd0 || m_awaddr !== 64'd0 || m_wdata !== 64'd0) begin
         n_fail++; $display("FAIL reset_values: got rdy/awv/wv/wl/br/idle/err=%b%b%b%b%b%b%b out=%0d nw=%0d aw=%h wd=%h required 1000110 0 0 0 0",
                            undo_log_ready, m_awvalid, m_wvalid, m_wlast, m_bready, idle, err, outstanding, n_writes, m_awaddr, m_wdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single;
      int w;
      @(posedge clk); #1;
      push_rec(7'd3, 3'd2, 32'h1000, 32'hAB, w);
      n_chk++;
      if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
         n_fail++; $display("FAIL single_early: got awv=%b wv=%b in N+1, required 0 0", m_awvalid, m_wvalid);
      end
      @(posedge clk); #1;
      n_chk++;
      if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_awaddr !== 64'h8000_00D0 || m_wdata !== 64'h0000_00AB_0000_1000) begin
         n_fail++; $display("FAIL single_n2: got awv=%b wv=%b aw=%h wd=%h required 1 1 80000d0 000000ab00001000", m_awvalid, m_wvalid, m_awaddr, m_wdata);
      end
      wait_idle("single");
      n_chk++;
      if (idle !== 1'b1 || n_writes !== 32'd1) begin
         n_fail++; $display("FAIL single_done: got idle=%b n_writes=%0d required 1 1", idle, n_writes);
      end
   endtask

   task automatic test_back_to_back;
      int w, stalls = 0;
      logic [31:0] nw0;
      @(posedge clk); #1;
      nw0 = n_writes;
      aw_cycles.delete();
      for (int i = 0; i < 8; i++) begin
         push_rec(7'd5, ID_W'(i), 32'h2000 + 32'(i * 4), $urandom, w);
         stalls += w;
      end
      wait_idle("b2b");
      n_chk++;
      if (stalls !== 0) begin
         n_fail++; $display("FAIL b2b_ready: got %0d stalled cycles, required 0", stalls);
      end
      n_chk++;
      if (aw_cycles.size() !== 8) begin
         n_fail++; $display("FAIL b2b_count: got %0d AW beats, required 8", aw_cycles.size());
      end else begin
         for (int i = 1; i < 8; i++) begin
            n_chk++;
            if (aw_cycles[i] !== aw_cycles[0] + i) begin
               n_fail++; $display("FAIL b2b_consecutive: got beat %0d at cycle %0d, required %0d", i, aw_cycles[i], aw_cycles[0] + i);
            end
         end
      end
      n_chk++;
      if (n_writes - nw0 !== 32'd8) begin
         n_fail++; $display("FAIL b2b_nwrites: got %0d, required 8", n_writes - nw0);
      end
   endtask

   task automatic test_backpressure;
      int w;
      @(posedge clk); #1;
      m_awready = 1'b0; m_wready = 1'b0;
      for (int i = 0; i < 5; i++) push_rec(7'd9, ID_W'(i), 32'h3000 + 32'(i), 32'hC0DE_0000 + 32'(i), w);
      n_chk++;
      if (undo_log_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_full: got ready=%b after 5 accepts, required 0", undo_log_ready);
      end
      undo_log_valid = 1'b1; undo_log_slot = 7'd9; undo_log_id = 3'd5;
      undo_log_addr = 32'h3005; undo_log_data = 32'hC0DE_0005;
      repeat (3) begin
         @(negedge clk);
         n_chk++;
         if (undo_log_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall: got ready=%b with 6th offered, required 0", undo_log_ready);
         end
      end
      @(posedge clk); #1;
      m_awready = 1'b1; m_wready = 1'b1;
      push_rec(7'd9, 3'd5, 32'h3005, 32'hC0DE_0005, w);
      wait_idle("bp");
   endtask

   task automatic test_channel_skew;
      int w, t, a0, w0;
      @(posedge clk); #1;
      a0 = aw_cnt; w0 = w_cnt;
      m_awready = 1'b0; m_wready = 1'b1;
      push_rec(7'd17, 3'd1, 32'h4000, 32'h1111_1111, w);
      t = 0;
      while (w_cnt == w0 && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      n_chk++;
      if (m_wvalid !== 1'b0 || m_awvalid !== 1'b1) begin
         n_fail++; $display("FAIL skew_w_first: got wv=%b awv=%b after W, required 0 1", m_wvalid, m_awvalid);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_awready = 1'b1;
      wait_idle("skew1");
      @(posedge clk); #1;
      m_wready = 1'b0;
      push_rec(7'd18, 3'd6, 32'h4004, 32'h2222_2222, w);
      t = 0;
      while (aw_cnt == a0 + 1 && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      n_chk++;
      if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1) begin
         n_fail++; $display("FAIL skew_aw_first: got awv=%b wv=%b after AW, required 0 1", m_awvalid, m_wvalid);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_wready = 1'b1;
      wait_idle("skew2");
      n_chk++;
      if (aw_cnt - a0 !== 2 || w_cnt - w0 !== 2) begin
         n_fail++; $display("FAIL skew_beats: got aw=%0d w=%0d, required 2 2", aw_cnt - a0, w_cnt - w0);
      end
   endtask

   task automatic test_outstanding_err;
      int w, a0;
      logic [31:0] nw0;
      @(posedge clk); #1;
      a0 = aw_cnt; nw0 = n_writes;
      b_en = 1'b0;
      for (int i = 0; i < 6; i++) push_rec(7'd33, ID_W'(i), 32'h5000 + 32'(i * 8), 32'hE000_0000 + 32'(i), w);
      repeat (10) @(negedge clk);
      n_chk++;
      if (aw_cnt - a0 !== 4 || outstanding !== 3'd4 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
         n_fail++; $display("FAIL cap: got loads=%0d out=%0d awv=%b wv=%b, required 4 4 0 0", aw_cnt - a0, outstanding, m_awvalid, m_wvalid);
      end
      n_chk++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL err_early: got %b, required 0", err);
      end
      @(posedge clk); #1;
      bad_next = 1'b1; b_en = 1'b1;
      repeat (4) @(negedge clk);
      n_chk++;
      if (err !== 1'b1) begin
         n_fail++; $display("FAIL err_set: got %b, required 1", err);
      end
      wait_idle("cap");
      n_chk++;
      if (err !== 1'b1 || aw_cnt - a0 !== 6 || n_writes - nw0 !== 32'd6) begin
         n_fail++; $display("FAIL cap_drain: got err=%b beats=%0d nw=%0d, required 1 6 6", err, aw_cnt - a0, n_writes - nw0);
      end
   endtask

   task automatic test_reset_midflight;
      int w, a0, w0;
      @(posedge clk); #1;
      m_awready = 1'b0; m_wready = 1'b0;
      for (int i = 0; i < 4; i++) push_rec(7'd40, ID_W'(i), 32'h6000 + 32'(i), 32'h7000 + 32'(i), w);
      #2;
      rst = 1'b1;
      exp_aw.delete(); exp_w.delete();
      #1;
      n_chk++;
      if ({undo_log_ready, m_awvalid, m_wvalid, m_wlast, m_bready, idle, err} !== 7'b1000110 ||
          outstanding !== 3'd0 || n_writes !== 32'd0 || m_awaddr !== 64'd0 || m_wdata !== 64'd0) begin
         n_fail++; $display("FAIL rst_mid: got rdy/awv/wv/wl/br/idle/err=%b%b%b%b%b%b%b out=%0d nw=%0d aw=%h wd=%h required 1000110 0 0 0 0",
                            undo_log_ready, m_awvalid, m_wvalid, m_wlast, m_bready, idle, err, outstanding, n_writes, m_awaddr, m_wdata);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      aw_cnt = 0; w_cnt = 0;
      a0 = aw_cnt; w0 = w_cnt;
      m_awready = 1'b1; m_wready = 1'b1;
      repeat (10) @(negedge clk);
      n_chk++;
      if (aw_cnt !== a0 || w_cnt !== w0 || m_awvalid !== 1'b0 || idle !== 1'b1) begin
         n_fail++; $display("FAIL rst_after: got aw=%0d w=%0d awv=%b idle=%b, required 0 0 0 1", aw_cnt - a0, w_cnt - w0, m_awvalid, idle);
      end
   endtask

   initial begin
      undo_log_valid = 1'b0;
      undo_log_slot  = '0;
      undo_log_id    = '0;
      undo_log_addr  = '0;
      undo_log_data  = '0;
      base_addr      = 64'h0000_0000_8000_0000;
      m_awready      = 1'b1;
      m_wready       = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      base_addr = 64'h0000_0012_3456_7FFB;
      test_backpressure();
      test_channel_skew();
      test_outstanding_err();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
